silly_stim_seq: RTL

- Synthesizable upstream stimulus sequencer and response capture stage for the `silly` 3-in/2-out combinational block.
- On `start`, drives `a`/`b`/`c` through the fixed 8-vector order 000, 001, 010, 100, 011, 110, 101, 111, holding each vector HOLD_CYCLES clocks.
- Samples `y`/`z` from the consumer before each vector advance and packs them into a 16-bit response word.
- Replaces the open-loop initial-block stimulus with a self-timed, restartable hardware stage usable on the board.

---
 rtl/silly_stim_seq_pkg.sv | 26 ++
 rtl/silly_stim_seq_if.sv | 45 ++++
 rtl/silly_stim_seq_lfsr.sv | 30 +++
 rtl/silly_stim_seq.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/silly_stim_seq_pkg.sv
// silly_stim_seq shared types and constants.
// Optional random tail: SILLY_SEQ_RANDOM_EN.
package silly_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RAND,
    DONE
  } state_t;

  localparam int NUM_VEC = 8;

  // Entry i is {a,b,c} for vector i.
  localparam logic [NUM_VEC-1:0][2:0] VEC_ORDER = {
    3'b111, 3'b101, 3'b110, 3'b011,
    3'b100, 3'b010, 3'b001, 3'b000
  };

  localparam logic [3:0] LFSR_SEED = 4'b1001;

  function automatic logic lfsr_fb(input logic [3:0] q);
    return q[3] ^ q[2];
  endfunction

endpackage

// File: rtl/silly_stim_seq_if.sv
// Stimulus/response bundle between sequencer and consumer.
// rand_resp exists only with SILLY_SEQ_RANDOM_EN.
interface silly_stim_seq_if
`ifdef SILLY_SEQ_RANDOM_EN
  #(parameter int N_RAND = 3)
`endif
  ;
  logic        start;
  logic        y_in;
  logic        z_in;
  logic        a;
  logic        b;
  logic        c;
  logic        busy;
  logic        done;
  logic [2:0]  vec_idx;
  logic [15:0] resp;
`ifdef SILLY_SEQ_RANDOM_EN
  logic [2*N_RAND-1:0] rand_resp;

  modport master (
    input  start, y_in, z_in,
    output a, b, c, busy, done,
    output vec_idx, resp, rand_resp
  );

  modport slave (
    output start, y_in, z_in,
    input  a, b, c, busy, done,
    input  vec_idx, resp, rand_resp
  );
`else
  modport master (
    input  start, y_in, z_in,
    output a, b, c, busy, done,
    output vec_idx, resp
  );

  modport slave (
    output start, y_in, z_in,
    input  a, b, c, busy, done,
    input  vec_idx, resp
  );
`endif
endinterface

// File: rtl/silly_stim_seq_lfsr.sv
// 4-bit Fibonacci LFSR, shift left, tap q[3]^q[2].
// Used only with SILLY_SEQ_RANDOM_EN.
module silly_seq_lfsr
  import silly_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       adv,
  output logic [1:0] tap,
  output logic [1:0] tap_nxt
);

  logic [3:0] q;

  // Seed on load, step on advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= LFSR_SEED;
    end else if (load) begin
      q <= LFSR_SEED;
    end else if (adv) begin
      q <= {q[2:0], lfsr_fb(q)};
    end
  end

  assign tap     = q[1:0];
  assign tap_nxt = {q[0], lfsr_fb(q)};

endmodule

// File: rtl/silly_stim_seq.sv
// Self-timed stimulus sequencer and response capture for silly.
// SILLY_SEQ_RANDOM_EN adds an LFSR-driven random tail.
module silly_stim_seq
  import silly_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
`ifdef SILLY_SEQ_RANDOM_EN
  ,
  parameter int N_RAND = 3
`endif
) (
  input  logic             clk,
  input  logic             reset,
  silly_stim_seq_if.master bus
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    abc_q, abc_d;
  logic [15:0]   resp_q, resp_d;
  logic          last_hold;

  assign last_hold = (cnt_q == CW'(HOLD_CYCLES - 1));

`ifdef SILLY_SEQ_RANDOM_EN
  localparam int RW = (N_RAND > 1) ? $clog2(N_RAND) : 1;

  logic [RW-1:0]       ridx_q, ridx_d;
  logic [2*N_RAND-1:0] rresp_q, rresp_d;
  logic                lfsr_load;
  logic                lfsr_adv;
  logic [1:0]          tap;
  logic [1:0]          tap_nxt;

  silly_seq_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (lfsr_load),
    .adv     (lfsr_adv),
    .tap     (tap),
    .tap_nxt (tap_nxt)
  );
`endif

  // Next-state, vector stepping and response capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    abc_d   = abc_q;
    resp_d  = resp_q;
`ifdef SILLY_SEQ_RANDOM_EN
    ridx_d    = ridx_q;
    rresp_d   = rresp_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
          idx_d   = '0;
          abc_d   = VEC_ORDER[0];
          resp_d  = '0;
`ifdef SILLY_SEQ_RANDOM_EN
          ridx_d    = '0;
          rresp_d   = '0;
          lfsr_load = 1'b1;
`endif
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (last_hold) begin
          cnt_d = '0;
          resp_d[{idx_q, 1'b0} +: 2] = {bus.y_in, bus.z_in};
          if (idx_q == 3'(NUM_VEC - 1)) begin
`ifdef SILLY_SEQ_RANDOM_EN
            state_d = RAND;
            abc_d   = {1'b1, tap[0], tap[1]};
`else
            state_d = DONE;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            abc_d = VEC_ORDER[idx_q + 3'd1];
          end
        end
      end
`ifdef SILLY_SEQ_RANDOM_EN
      RAND: begin
        cnt_d = cnt_q + 1'b1;
        if (last_hold) begin
          cnt_d    = '0;
          lfsr_adv = 1'b1;
          rresp_d[{ridx_q, 1'b0} +: 2] = {bus.y_in, bus.z_in};
          if (ridx_q == RW'(N_RAND - 1)) begin
            state_d = DONE;
          end else begin
            ridx_d = ridx_q + 1'b1;
            abc_d  = {1'b1, tap_nxt[0], tap_nxt[1]};
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      abc_q   <= '0;
      resp_q  <= '0;
`ifdef SILLY_SEQ_RANDOM_EN
      ridx_q  <= '0;
      rresp_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      abc_q   <= abc_d;
      resp_q  <= resp_d;
`ifdef SILLY_SEQ_RANDOM_EN
      ridx_q  <= ridx_d;
      rresp_q <= rresp_d;
`endif
    end
  end

  assign bus.a       = abc_q[2];
  assign bus.b       = abc_q[1];
  assign bus.c       = abc_q[0];
  assign bus.busy    = (state_q == RUN) || (state_q == RAND);
  assign bus.done    = (state_q == DONE);
  assign bus.vec_idx = idx_q;
  assign bus.resp    = resp_q;
`ifdef SILLY_SEQ_RANDOM_EN
  assign bus.rand_resp = rresp_q;
`endif

endmodule
